// File: rtl/ex_shared_unit_arbiter.sv
// -----------------------------------------------------------------------------
// ex_shared_unit_arbiter
//
// Shares one iterative multi-cycle execute unit (MUL/DIV) among NUM_CORES
// cores. Only one transaction is in flight at a time. Each transaction runs
// IDLE -> ISSUE -> WAIT -> RESP -> IDLE:
//   IDLE  : round-robin pick of a requester, accept pulse, latch operands
//   ISSUE : one-cycle launch pulse to the unit
//   WAIT  : wait for the unit's completion pulse and capture its result
//   RESP  : one-cycle response pulse to the granted core
//
// Optional feature (macro ARB_TIMEOUT_EN): a watchdog in WAIT. After
// TIMEOUT_CYCLES WAIT cycles without unit_done the transaction completes with
// rsp_data=0 and rsp_err=1. Without the macro there is no counter, rsp_err is
// tied to 0 and WAIT waits indefinitely.
//
// Ports
//   clk          clock, all logic on rising edge
//   rst_n        synchronous active-low reset
//   req_valid    [NUM_CORES]       per-core request
//   req_ready    [NUM_CORES]       one-hot accept pulse (combinational, IDLE)
//   req_rs1      [NUM_CORES*XLEN]  operand A, core i at [i*XLEN +: XLEN]
//   req_rs2      [NUM_CORES*XLEN]  register operand B
//   req_imm      [NUM_CORES*XLEN]  immediate operand B
//   req_alu_src  [NUM_CORES]       1: operand B = imm, 0: operand B = rs2
//   req_op       [NUM_CORES*OP_W]  unit opcode
//   unit_start   one-cycle launch pulse
//   unit_op      [OP_W]  latched opcode
//   unit_a       [XLEN]  latched operand A
//   unit_b       [XLEN]  latched operand B
//   unit_done    unit completion pulse
//   unit_result  [XLEN]  unit result, valid with unit_done
//   rsp_valid    [NUM_CORES]  one-hot one-cycle response pulse
//   rsp_data     [XLEN]  response data, held until the next response
//   rsp_err      timeout flag, held until the next response
//   busy         high in every state except IDLE
// -----------------------------------------------------------------------------
module ex_shared_unit_arbiter #(
  parameter int NUM_CORES      = 4,
  parameter int XLEN           = 32,
  parameter int OP_W           = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CORES-1:0]      req_valid,
  output logic [NUM_CORES-1:0]      req_ready,
  input  logic [NUM_CORES*XLEN-1:0] req_rs1,
  input  logic [NUM_CORES*XLEN-1:0] req_rs2,
  input  logic [NUM_CORES*XLEN-1:0] req_imm,
  input  logic [NUM_CORES-1:0]      req_alu_src,
  input  logic [NUM_CORES*OP_W-1:0] req_op,
  output logic                      unit_start,
  output logic [OP_W-1:0]           unit_op,
  output logic [XLEN-1:0]           unit_a,
  output logic [XLEN-1:0]           unit_b,
  input  logic                      unit_done,
  input  logic [XLEN-1:0]           unit_result,
  output logic [NUM_CORES-1:0]      rsp_valid,
  output logic [XLEN-1:0]           rsp_data,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   last_grant_q;

  logic            any_req;
  logic [GW-1:0]   pick;
  logic [XLEN-1:0] pick_rs1;
  logic [XLEN-1:0] pick_b;
  logic [OP_W-1:0] pick_op;

  logic            timeout_hit;

  // ---------------------------------------------------------------------------
  // Round-robin pick: scan upward from last_grant+1, wrapping at NUM_CORES.
  // The first valid index found wins; later hits are ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    int            idx;
    logic [GW-1:0] cand;
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves it unassigned and no latch is inferred.
    any_req = 1'b0;
    pick    = '0;
    idx     = 0;
    cand    = '0;
    for (int off = 1; off <= NUM_CORES; off++) begin
      idx = int'(last_grant_q) + off;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      cand = GW'(idx);
      if (!any_req && req_valid[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  // Operand selection for the picked core; operand B is built here so the
  // unit only ever sees final operands.
  always_comb begin
    pick_rs1 = req_rs1[pick*XLEN +: XLEN];
    pick_op  = req_op[pick*OP_W +: OP_W];
    pick_b   = req_alu_src[pick] ? req_imm[pick*XLEN +: XLEN]
                                 : req_rs2[pick*XLEN +: XLEN];
  end

  // ---------------------------------------------------------------------------
  // Optional WAIT watchdog
  // ---------------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt_q;
  logic          rsp_err_q;

  // wait_cnt_q counts completed WAIT cycles; the cycle holding the value
  // TIMEOUT_CYCLES-1 is the last one allowed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_ISSUE) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_WAIT) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == S_WAIT) && !unit_done &&
                       (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else if (state_q == S_WAIT) begin
      if (unit_done)        rsp_err_q <= 1'b0;
      else if (timeout_hit) rsp_err_q <= 1'b1;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;  // unit_done is deliberately ignored here
      S_WAIT:  if (unit_done || timeout_hit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too, because outputs must read 0
    // straight out of reset rather than holding stale operands.
    if (!rst_n) begin
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_CORES - 1);
      unit_a       <= '0;
      unit_b       <= '0;
      unit_op      <= '0;
      rsp_data     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            grant_q <= pick;
            unit_a  <= pick_rs1;
            unit_b  <= pick_b;
            unit_op <= pick_op;
          end
        end
        S_WAIT: begin
          if (unit_done)        rsp_data <= unit_result;
          else if (timeout_hit) rsp_data <= '0;
        end
        S_RESP: begin
          last_grant_q <= grant_q;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Accept is combinational in IDLE and masked during reset so all outputs
  // read 0 while rst_n is low.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == S_IDLE) && any_req) req_ready[pick] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == S_RESP) rsp_valid[grant_q] = 1'b1;
  end

  assign unit_start = (state_q == S_ISSUE);
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ex_shared_unit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ex_shared_unit_arbiter
//
// Directed bench for ex_shared_unit_arbiter (NUM_CORES=4, XLEN=32, OP_W=4).
// A table of single-core transactions checks accept, operand build, launch,
// latency and response; hand-written sequences cover round-robin order,
// alternation, reset during WAIT and (with ARB_TIMEOUT_EN) the watchdog.
// Inputs are driven just after the falling edge, outputs sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_ex_shared_unit_arbiter;

  localparam int NC = 4;
  localparam int XL = 32;
  localparam int OW = 4;

  logic             clk;
  logic             rst_n;
  logic [NC-1:0]    req_valid;
  logic [NC-1:0]    req_ready;
  logic [NC*XL-1:0] req_rs1;
  logic [NC*XL-1:0] req_rs2;
  logic [NC*XL-1:0] req_imm;
  logic [NC-1:0]    req_alu_src;
  logic [NC*OW-1:0] req_op;
  logic             unit_start;
  logic [OW-1:0]    unit_op;
  logic [XL-1:0]    unit_a;
  logic [XL-1:0]    unit_b;
  logic             unit_done;
  logic [XL-1:0]    unit_result;
  logic [NC-1:0]    rsp_valid;
  logic [XL-1:0]    rsp_data;
  logic             rsp_err;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  ex_shared_unit_arbiter #(
    .NUM_CORES(NC), .XLEN(XL), .OP_W(OW), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .req_alu_src(req_alu_src), .req_op(req_op),
    .unit_start(unit_start), .unit_op(unit_op),
    .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done), .unit_result(unit_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          core;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        alu_src;
    logic [3:0]  op;
    int          k;        // WAIT cycles up to and including unit_done
    logic [31:0] result;
    logic [31:0] exp_b;    // hand-computed operand B
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid   = '0;
    req_rs1     = '0;
    req_rs2     = '0;
    req_imm     = '0;
    req_alu_src = '0;
    req_op      = '0;
  endtask

  task automatic drive_core(input int c, input logic [31:0] rs1,
                            input logic [31:0] rs2, input logic [31:0] imm,
                            input logic src, input logic [3:0] op);
    req_valid[c]          = 1'b1;
    req_rs1[c*XL +: XL]   = rs1;
    req_rs2[c*XL +: XL]   = rs2;
    req_imm[c*XL +: XL]   = imm;
    req_alu_src[c]        = src;
    req_op[c*OW +: OW]    = op;
  endtask

  // Holds reset for two cycles, checks outputs, releases at a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '1;
    unit_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst req_ready",  64'(req_ready),  64'h0);
    check("rst unit_start", 64'(unit_start), 64'h0);
    check("rst rsp_valid",  64'(rsp_valid),  64'h0);
    check("rst busy",       64'(busy),       64'h0);
    check("rst unit_a",     64'(unit_a),     64'h0);
    check("rst rsp_data",   64'(rsp_data),   64'h0);
    check("rst rsp_err",    64'(rsp_err),    64'h0);
    clear_reqs();
    rst_n = 1'b1;
  endtask

  // Full single-core transaction; starts and ends at an IDLE sample point.
  task automatic run_txn(input vec_t v);
    logic [3:0] oh;
    oh = 4'b0001 << v.core;
    check("txn idle busy", 64'(busy), 64'h0);
    drive_core(v.core, v.rs1, v.rs2, v.imm, v.alu_src, v.op);
    #1;
    check("txn req_ready", 64'(req_ready), 64'(oh));
    // ISSUE; a stray done here must be ignored
    next_cycle();
    clear_reqs();
    unit_done   = 1'b1;
    unit_result = 32'hBAD0_0000;
    #1;
    check("txn unit_start", 64'(unit_start), 64'h1);
    check("txn unit_a",     64'(unit_a),     64'(v.rs1));
    check("txn unit_b",     64'(unit_b),     64'(v.exp_b));
    check("txn unit_op",    64'(unit_op),    64'(v.op));
    check("txn issue rdy",  64'(req_ready),  64'h0);
    for (int j = 1; j <= v.k; j++) begin
      next_cycle();
      unit_done   = (j == v.k);
      unit_result = (j == v.k) ? v.result : 32'hBAD0_0000 + 32'(j);
      #1;
      check("txn wait start", 64'(unit_start), 64'h0);
      check("txn wait rsp",   64'(rsp_valid),  64'h0);
      check("txn wait busy",  64'(busy),       64'h1);
    end
    // RESP
    next_cycle();
    unit_done = 1'b0;
    #1;
    check("txn rsp_valid", 64'(rsp_valid), 64'(oh));
    check("txn rsp_data",  64'(rsp_data),  64'(v.result));
    check("txn rsp_err",   64'(rsp_err),   64'h0);
    check("txn b stable",  64'(unit_b),    64'(v.exp_b));
    next_cycle();
    check("txn post rsp",  64'(rsp_valid), 64'h0);
    check("txn data hold", 64'(rsp_data),  64'(v.result));
  endtask

  // Waits (bounded) for an accept with req_valid held by the caller, checks
  // the winner, answers after one WAIT cycle and checks the response.
  task automatic serve_one(input int exp_core, input logic [31:0] res);
    logic [3:0] oh;
    oh = 4'b0001 << exp_core;
    for (int i = 0; i < 8; i++) begin
      if (req_ready != '0) break;
      next_cycle();
    end
    check("rr grant", 64'(req_ready), 64'(oh));
    next_cycle();
    check("rr issue start", 64'(unit_start), 64'h1);
    check("rr issue rdy",   64'(req_ready),  64'h0);
    next_cycle();
    unit_done   = 1'b1;
    unit_result = res;
    #1;
    check("rr wait rdy", 64'(req_ready), 64'h0);
    next_cycle();
    unit_done = 1'b0;
    #1;
    check("rr rsp_valid", 64'(rsp_valid), 64'(oh));
    check("rr rsp_data",  64'(rsp_data),  64'(res));
    check("rr resp rdy",  64'(req_ready), 64'h0);
    next_cycle();
  endtask

  initial begin
    rst_n       = 1'b0;
    unit_done   = 1'b0;
    unit_result = '0;
    clear_reqs();

    //            core rs1           rs2           imm           src op    k  result        exp_b
    vecs[0] = '{1, 32'h5,        32'hAAAA,     32'h10,       1'b1, 4'h2, 3, 32'h15,       32'h10};
    vecs[1] = '{3, 32'h1234,     32'h7,        32'h99,       1'b0, 4'h5, 1, 32'hDEAD,     32'h7};
    vecs[2] = '{0, 32'hFFFFFFFF, 32'h1,        32'h2,        1'b1, 4'hF, 6, 32'hFFFFFFFE, 32'h2};
    vecs[3] = '{2, 32'h0,        32'h80000000, 32'h5,        1'b0, 4'h1, 2, 32'h0,        32'h80000000};
    vecs[4] = '{1, 32'hCAFE0001, 32'h3,        32'hFFFF0000, 1'b1, 4'h9, 1, 32'h12345678, 32'hFFFF0000};

    do_reset();
    #1;
    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // All four cores hold valid after reset: 0,1,2,3, then 0 again.
    do_reset();
    for (int c = 0; c < NC; c++)
      drive_core(c, 32'(c + 1), 32'h0, 32'h0, 1'b0, 4'h0);
    #1;
    for (int n = 0; n < 5; n++) serve_one(n % NC, 32'h100 + 32'(n));
    clear_reqs();

    // Cores 0 and 2 request continuously: 0,2,0,2.
    do_reset();
    drive_core(0, 32'h1, 32'h0, 32'h0, 1'b0, 4'h0);
    drive_core(2, 32'h2, 32'h0, 32'h0, 1'b0, 4'h0);
    #1;
    serve_one(0, 32'hA0);
    serve_one(2, 32'hA2);
    serve_one(0, 32'hB0);
    serve_one(2, 32'hB2);
    clear_reqs();

    // Reset for one cycle during WAIT drops the transaction.
    do_reset();
    drive_core(1, 32'h77, 32'h0, 32'h0, 1'b0, 4'h3);
    #1;
    check("rstw accept", 64'(req_ready), 64'h2);
    next_cycle();              // ISSUE
    clear_reqs();
    next_cycle();              // WAIT
    check("rstw in wait", 64'(busy), 64'h1);
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    #1;
    check("rstw busy",   64'(busy),      64'h0);
    check("rstw unit_a", 64'(unit_a),    64'h0);
    unit_done   = 1'b1;
    unit_result = 32'h5555;
    next_cycle();
    unit_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rstw no rsp", 64'(rsp_valid), 64'h0);
      next_cycle();
    end
    drive_core(2, 32'h22, 32'h0, 32'h0, 1'b0, 4'h0);
    #1;
    serve_one(2, 32'h2222);
    clear_reqs();

`ifdef ARB_TIMEOUT_EN
    begin
      int cycles;
      do_reset();
      drive_core(0, 32'h9, 32'h0, 32'h0, 1'b0, 4'h4);
      #1;
      check("to accept", 64'(req_ready), 64'h1);
      next_cycle();            // ISSUE
      clear_reqs();
      cycles = 0;
      for (int i = 0; i < 100; i++) begin
        next_cycle();
        cycles++;
        if (rsp_valid != '0) break;
      end
      check("to wait cycles", 64'(cycles - 1), 64'd64);
      check("to rsp_valid",   64'(rsp_valid),  64'h1);
      check("to rsp_err",     64'(rsp_err),    64'h1);
      check("to rsp_data",    64'(rsp_data),   64'h0);
      next_cycle();
      check("to idle", 64'(busy), 64'h0);
      unit_done   = 1'b1;     // late done while IDLE
      unit_result = 32'hFEED;
      next_cycle();
      unit_done = 1'b0;
      #1;
      check("to late busy", 64'(busy),      64'h0);
      check("to late rsp",  64'(rsp_valid), 64'h0);
      check("to err hold",  64'(rsp_err),   64'h1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
